axi_read_write_master: RTL

- AXI4 master-side bridge between a CPU memory port (instruction or data) and the AXI bus; the initiator counterpart of the team's slave wrappers.
- Converts one core request into one AXI transaction: a single-beat write, or an INCR read burst of READ_LEN+1 beats (line fill).
- Returns read beats to the core and stalls it until the transaction completes.
- Only one transaction is outstanding at a time.

---
 rtl/axi_read_write_master_pkg.sv | 30 +++
 rtl/axi_read_fsm.sv | 114 +++++++++++
 rtl/axi_read_write_master.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_write_master_pkg.sv
// -----------------------------------------------------------------------------
// axi_read_write_master_pkg
// Shared types and constants for the AXI4 read/write master bridge:
//   - transaction state enum used by the top-level FSM
//   - AXI encoding constants (size, burst type, response)
//   - channel width constants
// -----------------------------------------------------------------------------
package axi_read_write_master_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int STRB_W = 4;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

endpackage

// File: rtl/axi_read_fsm.sv
// -----------------------------------------------------------------------------
// axi_read_fsm
// Read path of the AXI master: issues one INCR burst of READ_LEN+1 beats on
// AR, accepts the beats on R, forwards each beat to the core one cycle later
// and accumulates a sticky error flag for the transaction.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_start             pulse: latch i_addr and begin a new burst
//   i_addr              burst start address
//   ar*_o / arready_i   AXI read-address channel
//   r*_i / rready_o     AXI read-data channel
//   o_ar_hs             AR handshake this cycle
//   o_last              terminal R beat accepted this cycle
//   o_err               error flag including the beat accepted this cycle
//   o_cpu_rvalid/rdata  registered read beat towards the core
// -----------------------------------------------------------------------------
module axi_read_fsm
    import axi_read_write_master_pkg::*;
#(
    parameter logic [ID_W-1:0]  MASTER_ID = 4'h0,
    parameter logic [LEN_W-1:0] READ_LEN  = 4'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ID_W-1:0]   arid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [LEN_W-1:0]  arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [ID_W-1:0]   rid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic              o_ar_hs,
    output logic              o_last,
    output logic              o_err,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata
);

    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_rready;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_cpu_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic w_r_hs;
    logic w_cnt_last;
    logic w_beat_err;

    assign w_r_hs     = r_rready & rvalid_i;
    assign w_cnt_last = (r_cnt == READ_LEN);
    // The slave's rlast must agree with our own beat count; either one ends
    // the burst so a misbehaving slave cannot hang the core.
    assign w_beat_err = (rresp_i != AXI_RESP_OKAY) | (rid_i != MASTER_ID) |
                        (rlast_i != w_cnt_last);

    assign o_ar_hs = r_arvalid & arready_i;
    assign o_last  = w_r_hs & (rlast_i | w_cnt_last);
    assign o_err   = r_err | (w_r_hs & w_beat_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_rready     <= 1'b0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_r_hs;
            if (w_r_hs) begin
                r_cpu_rdata <= rdata_i;
            end

            if (i_start) begin
                r_arvalid <= 1'b1;
                r_araddr  <= i_addr;
                r_cnt     <= '0;
                r_err     <= 1'b0;
            end else if (o_ar_hs) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
            end else if (w_r_hs) begin
                r_err <= o_err;
                if (o_last) begin
                    r_rready <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    assign arid_o       = MASTER_ID;
    assign araddr_o     = r_araddr;
    assign arlen_o      = READ_LEN;
    assign arsize_o     = AXI_SIZE_WORD;
    assign arburst_o    = AXI_BURST_INCR;
    assign arvalid_o    = r_arvalid;
    assign rready_o     = r_rready;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_cpu_rdata  = r_cpu_rdata;

endmodule

// File: rtl/axi_read_write_master.sv
// -----------------------------------------------------------------------------
// axi_read_write_master
// AXI4 master bridge for a CPU memory port. Each accepted core request becomes
// one AXI transaction: a single-beat write (AW, W, B) or an INCR read burst of
// READ_LEN+1 beats (AR, R). The core is stalled until the transaction ends;
// completion is a one-cycle cpu_done_o pulse with cpu_err_o alongside.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i/...      core request
//   cpu_stall_o                    core must hold its request
//   cpu_rvalid_o/cpu_rdata_o       read beat to the core
//   cpu_done_o/cpu_err_o           completion pulse and its error status
//   AR/R/AW/W/B channel signals    AXI4 master interface
// -----------------------------------------------------------------------------
module axi_read_write_master
    import axi_read_write_master_pkg::*;
#(
    parameter logic [ID_W-1:0]  MASTER_ID = 4'h0,
    parameter logic [LEN_W-1:0] READ_LEN  = 4'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [STRB_W-1:0] cpu_wstrb_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_done_o,
    output logic              cpu_err_o,
    output logic [ID_W-1:0]   arid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [LEN_W-1:0]  arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [ID_W-1:0]   rid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [ID_W-1:0]   awid_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [LEN_W-1:0]  awlen_o,
    output logic [2:0]        awsize_o,
    output logic [1:0]        awburst_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              wlast_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [ID_W-1:0]   bid_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [STRB_W-1:0] r_wstrb;
    logic [DATA_W-1:0] r_wdata;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_done;
    logic              r_cpu_err;

    logic w_rd_start;
    logic w_ar_hs;
    logic w_rd_last;
    logic w_rd_err;

    assign w_rd_start = (r_state == ST_IDLE) & cpu_req_i & ~cpu_we_i;

    axi_read_fsm #(
        .MASTER_ID (MASTER_ID),
        .READ_LEN  (READ_LEN)
    ) u_read (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_rd_start),
        .i_addr       (cpu_addr_i),
        .arid_o       (arid_o),
        .araddr_o     (araddr_o),
        .arlen_o      (arlen_o),
        .arsize_o     (arsize_o),
        .arburst_o    (arburst_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rid_i        (rid_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rlast_i      (rlast_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .o_ar_hs      (w_ar_hs),
        .o_last       (w_rd_last),
        .o_err        (w_rd_err),
        .o_cpu_rvalid (cpu_rvalid_o),
        .o_cpu_rdata  (cpu_rdata_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wstrb   <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_cpu_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req_i) begin
                        r_addr  <= cpu_addr_i;
                        r_wstrb <= cpu_wstrb_i;
                        r_wdata <= cpu_wdata_i;
                        if (cpu_we_i) begin
                            r_awvalid <= 1'b1;
                            r_state   <= ST_AW;
                        end else begin
                            r_state <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (w_ar_hs) begin
                        r_state <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_rd_last) begin
                        r_done    <= 1'b1;
                        r_cpu_err <= w_rd_err;
                        r_state   <= ST_DONE;
                    end
                end
                ST_AW: begin
                    if (awready_i) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (wready_i) begin
                        r_wvalid <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (bvalid_i) begin
                        r_bready  <= 1'b0;
                        r_done    <= 1'b1;
                        r_cpu_err <= (bresp_i != AXI_RESP_OKAY) | (bid_i != MASTER_ID);
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests are never taken here, so a request held high
                    // through completion is only re-accepted from IDLE.
                    r_done    <= 1'b0;
                    r_cpu_err <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cpu_stall_o = 1'b1;
        case (r_state)
            ST_IDLE: cpu_stall_o = cpu_req_i;
            ST_DONE: cpu_stall_o = 1'b0;
            default: cpu_stall_o = 1'b1;
        endcase
    end

    assign cpu_done_o = r_done;
    assign cpu_err_o  = r_cpu_err;

    assign awid_o    = MASTER_ID;
    assign awaddr_o  = r_addr;
    assign awlen_o   = '0;
    assign awsize_o  = AXI_SIZE_WORD;
    assign awburst_o = AXI_BURST_INCR;
    assign awvalid_o = r_awvalid;
    assign wdata_o   = r_wdata;
    assign wstrb_o   = r_wstrb;
    assign wlast_o   = r_wvalid;
    assign wvalid_o  = r_wvalid;
    assign bready_o  = r_bready;

endmodule
